alu4_cmd_loader: RTL and testbench
==================================

Name: alu4_cmd_loader

Overview:
- Initiator side of the 4-bit ALU operand interface.
- Converts board switches and a push-button into a sequenced A/B/sel/en command for the ALU.
- Operator sets switches, presses ENTER, and advances through LOAD_A -> LOAD_B -> LOAD_OP -> RUN.
- Sits between the nvboard switch/button inputs and the ALU; its state drives the status LEDs.

Parameters:
- DB_CYCLES, 16'd50000, clock cycles a synchronized button level must hold stable to count as a press.
- DB_W, 16, width of the debounce counter; DB_CYCLES must fit in DB_W bits.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sw  input  4  data switches (operand value or opcode in low 3 bits)
- btn_enter  input  1  raw ENTER button, active-high, asynchronous to clk
- btn_clr  input  1  raw CLEAR button, active-high, asynchronous to clk
- alu_c  input  4  ALU result, signed
- a  output  4  operand A to ALU, signed
- b  output  4  operand B to ALU, signed
- sel  output  3  opcode to ALU
- en  output  1  ALU enable
- state_o  output  2  current state: 00 LOAD_A, 01 LOAD_B, 10 LOAD_OP, 11 RUN
- cmd_vld  output  1  one-cycle pulse on entry to RUN
- res_q  output  4  latched result (optional feature)
- res_vld  output  1  latched result valid (optional feature)

Behaviour:
- Reset, asynchronous, active-low. All outputs go to 0; state is LOAD_A; synchronizers and debounce counters are cleared.
- Input conditioning:
  - Each button passes through a 2-flop synchronizer, then its own debouncer.
  - The debouncer counter resets whenever the synchronized level differs from the debounced level.
  - The debounced level toggles when the counter reaches DB_CYCLES-1.
  - A press event is a one-cycle pulse on the debounced 0->1 edge.
  - Button-to-event latency: 2 sync cycles + DB_CYCLES + 1 cycles.
- sw is used unsynchronized and sampled only on the event cycle. Operator holds switches static while pressing.
- FSM, advancing only on an enter event:
  - LOAD_A: a <= sw; next LOAD_B.
  - LOAD_B: b <= sw; next LOAD_OP.
  - LOAD_OP: sel <= sw[2:0]; next RUN. en <= 1 and cmd_vld <= 1 in the same cycle as the transition.
  - RUN: en stays 1 while in RUN.
    - Enter event -> LOAD_A with en <= 0.
    - a, b and sel keep their values until overwritten.
  - All register updates occur one cycle after the event (registered outputs).
- Clear: a clear event from any state forces LOAD_A and sets en, cmd_vld and res_vld to 0. a, b and sel are also cleared to 0.
- Simultaneous enter and clear events: clear wins.
- cmd_vld is high for exactly one cycle per RUN entry and never while holding in RUN.
- A held button produces exactly one event until release and re-press, debounced both edges.
- Bounce shorter than DB_CYCLES produces no event.
- en never glitches. In states other than RUN, en = 0.
- Reset asserted mid-RUN: en drops asynchronously to 0.

Optional Feature:
- Macro: ALU4_CMD_LOADER_RESULT_LATCH_EN.
- Defined:
  - res_q <= alu_c on the cycle after cmd_vld, giving the ALU one full cycle to settle.
  - res_vld <= 1 at the same time.
  - Both are held through RUN and the following load states.
  - res_vld is cleared by clear, by reset, or on the next LOAD_OP -> RUN transition, then set again one cycle later.
  - alu_c is otherwise ignored.
- Undefined: res_q and res_vld are tied to 0, alu_c is unused, and no result register is synthesized.

Test Plan:
- Set DB_CYCLES=4. Reset, then sequence sw=4'h3 enter, sw=4'hE enter, sw=4'h0 enter:
  - a=3, b=-2, sel=000, en=1.
  - cmd_vld is a single pulse; state_o=11.
- Bounce: toggle btn_enter every 2 cycles for 10 cycles, then hold high 10 cycles:
  - exactly one event; state goes LOAD_A -> LOAD_B; a equals sw at the event.
- In RUN, press enter -> en=0, state_o=00, a/b/sel unchanged. Hold btn_enter 100 cycles -> no further transitions.
- In LOAD_OP, press enter and clear so their events land on the same cycle -> state_o=00, en=0, a=b=sel=0, cmd_vld never pulses.
- In RUN, assert rst_n=0 between clock edges -> en and all outputs go to 0 immediately. Release -> state_o=00.
- With RESULT_LATCH_EN, load a=5, b=2, sel=001 and drive alu_c=3 from the ALU model:
  - the cycle after cmd_vld: res_q=3, res_vld=1.
  - a clear event gives res_vld=0.

Source files
------------

// File: rtl/alu4_cmd_loader.sv
// +-----------------------------------------------------------------------------+
// | Module   : alu4_cmd_loader                                                  |
// | Function : Switch/button command sequencer for the 4-bit ALU (A, B, op, run)|
// | Option   : ALU4_CMD_LOADER_RESULT_LATCH_EN adds a latched ALU result        |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module alu4_cmd_loader #(
    parameter int              DB_W      = 16,
    parameter logic [DB_W-1:0] DB_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       btn_enter,
    input  logic       btn_clr,
    input  logic [3:0] alu_c,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [2:0] sel,
    output logic       en,
    output logic [1:0] state_o,
    output logic       cmd_vld,
    output logic [3:0] res_q,
    output logic       res_vld
);

    typedef enum logic [1:0] {
        S_LOAD_A  = 2'b00,
        S_LOAD_B  = 2'b01,
        S_LOAD_OP = 2'b10,
        S_RUN     = 2'b11
    } state_t;

    localparam logic [DB_W-1:0] c_CNT_ONE = {{(DB_W-1){1'b0}}, 1'b1};

    logic [1:0] w_btn_raw;
    logic [1:0] w_btn_evt;
    logic       w_ent_evt;
    logic       w_clr_evt;

    assign w_btn_raw = {btn_clr, btn_enter};
    assign w_ent_evt = w_btn_evt[0];
    assign w_clr_evt = w_btn_evt[1];

    // Both buttons share an identical sync+debounce pipe so simultaneous presses align.
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic [1:0]      r_sync;
        logic            r_db;
        logic [DB_W-1:0] r_cnt;
        logic            r_evt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync <= 2'b00;
                r_db   <= 1'b0;
                r_cnt  <= '0;
                r_evt  <= 1'b0;
            end else begin
                r_sync <= {r_sync[0], w_btn_raw[gi]};
                r_evt  <= 1'b0;
                if (r_sync[1] == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == DB_CYCLES - c_CNT_ONE) begin
                    r_cnt <= '0;
                    r_db  <= r_sync[1];
                    r_evt <= r_sync[1];
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end
        end

        assign w_btn_evt[gi] = r_evt;
    end

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [2:0] r_sel;
    logic       r_en;
    logic       r_cmd_vld;
    logic [3:0] w_a_nxt;
    logic [3:0] w_b_nxt;
    logic [2:0] w_sel_nxt;
    logic       w_en_nxt;
    logic       w_cmd_vld_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_LOAD_A;
            r_a       <= 4'h0;
            r_b       <= 4'h0;
            r_sel     <= 3'b000;
            r_en      <= 1'b0;
            r_cmd_vld <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_a       <= w_a_nxt;
            r_b       <= w_b_nxt;
            r_sel     <= w_sel_nxt;
            r_en      <= w_en_nxt;
            r_cmd_vld <= w_cmd_vld_nxt;
        end
    end

    // Clear has priority over enter when both events land on the same cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_a_nxt       = r_a;
        w_b_nxt       = r_b;
        w_sel_nxt     = r_sel;
        w_cmd_vld_nxt = 1'b0;
        if (w_clr_evt) begin
            w_state_nxt = S_LOAD_A;
            w_a_nxt     = 4'h0;
            w_b_nxt     = 4'h0;
            w_sel_nxt   = 3'b000;
        end else if (w_ent_evt) begin
            case (r_state)
                S_LOAD_A: begin
                    w_a_nxt     = sw;
                    w_state_nxt = S_LOAD_B;
                end
                S_LOAD_B: begin
                    w_b_nxt     = sw;
                    w_state_nxt = S_LOAD_OP;
                end
                S_LOAD_OP: begin
                    w_sel_nxt     = sw[2:0];
                    w_state_nxt   = S_RUN;
                    w_cmd_vld_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt = S_LOAD_A;
                end
            endcase
        end
        w_en_nxt = (w_state_nxt == S_RUN);
    end

    assign a       = r_a;
    assign b       = r_b;
    assign sel     = r_sel;
    assign en      = r_en;
    assign state_o = r_state;
    assign cmd_vld = r_cmd_vld;

`ifdef ALU4_CMD_LOADER_RESULT_LATCH_EN
    logic [3:0] r_res_q;
    logic       r_res_vld;

    // Capture one cycle after cmd_vld so the ALU sees stable operands for a full cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_q   <= 4'h0;
            r_res_vld <= 1'b0;
        end else if (w_clr_evt || w_cmd_vld_nxt) begin
            r_res_vld <= 1'b0;
        end else if (r_cmd_vld) begin
            r_res_q   <= alu_c;
            r_res_vld <= 1'b1;
        end
    end

    assign res_q   = r_res_q;
    assign res_vld = r_res_vld;
`else
    logic w_unused_alu_c;

    assign w_unused_alu_c = ^alu_c;
    assign res_q          = 4'h0;
    assign res_vld        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu4_cmd_loader.sv
// Self-checking bench for alu4_cmd_loader with a small debounce window.
`default_nettype none

module tb_alu4_cmd_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       btn_enter;
    logic       btn_clr;
    logic [3:0] alu_c;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic       en;
    logic [1:0] state_o;
    logic       cmd_vld;
    logic [3:0] res_q;
    logic       res_vld;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    // Behavioural model of the command sequence
    int         m_state;
    logic [3:0] m_a;
    logic [3:0] m_b;
    logic [2:0] m_sel;
    logic       m_en;
    int         m_pulses = 0;

    alu4_cmd_loader #(.DB_W(16), .DB_CYCLES(16'd4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn_enter(btn_enter),
        .btn_clr  (btn_clr),
        .alu_c    (alu_c),
        .a        (a),
        .b        (b),
        .sel      (sel),
        .en       (en),
        .state_o  (state_o),
        .cmd_vld  (cmd_vld),
        .res_q    (res_q),
        .res_vld  (res_vld)
    );

    always #5 clk = ~clk;

    // Simple ALU: sel 001 subtracts, anything else adds
    always_comb alu_c = (sel == 3'b001) ? (a - b) : (a + b);

    always @(negedge clk) if (rst_n && cmd_vld) pulses++;

    task automatic m_reset();
        m_state = 0; m_a = 4'h0; m_b = 4'h0; m_sel = 3'b000; m_en = 1'b0;
    endtask

    task automatic m_enter(input logic [3:0] v);
        case (m_state)
            0: m_a = v;
            1: m_b = v;
            2: begin m_sel = v[2:0]; m_en = 1'b1; m_pulses++; end
            default: m_en = 1'b0;
        endcase
        m_state = (m_state + 1) % 4;
    endtask

    task automatic press(input logic e, input logic c, input int hold);
        @(negedge clk);
        btn_enter = e;
        btn_clr   = c;
        repeat (hold) @(negedge clk);
        btn_enter = 1'b0;
        btn_clr   = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic do_enter(input logic [3:0] v);
        sw = v;
        press(1'b1, 1'b0, 12);
        m_enter(v);
    endtask

    task automatic do_clear();
        press(1'b0, 1'b1, 12);
        m_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sw = 4'h0; btn_enter = 1'b0; btn_clr = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({state_o, a, b, sel, en, cmd_vld, res_q, res_vld} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 00000", {state_o, a, b, sel, en, cmd_vld, res_q, res_vld});
        end
        rst_n = 1'b1;
        m_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sequence();
        do_enter(4'h3);
        do_enter(4'hE);
        do_enter(4'h0);
        total++;
        if ({state_o, a, b, sel, en} !== {2'b11, 4'h3, 4'hE, 3'b000, 1'b1}) begin
            bad++;
            $display("FAIL seq_outputs: got st=%b a=%h b=%h sel=%b en=%b want st=11 a=3 b=e sel=000 en=1",
                     state_o, a, b, sel, en);
        end
        total++;
        if (pulses !== 1) begin
            bad++;
            $display("FAIL seq_cmd_vld_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_random();
        logic [3:0] v;
        for (int i = 0; i < 14; i++) begin
            v = 4'($urandom);
            if ($urandom_range(0, 5) == 0) do_clear();
            else do_enter(v);
            total++;
            if ({state_o, a, b, sel, en} !== {2'(m_state), m_a, m_b, m_sel, m_en}) begin
                bad++;
                $display("FAIL random_step%0d: got st=%b a=%h b=%h sel=%b en=%b want st=%b a=%h b=%h sel=%b en=%b",
                         i, state_o, a, b, sel, en, 2'(m_state), m_a, m_b, m_sel, m_en);
            end
        end
        total++;
        if (pulses !== m_pulses) begin
            bad++;
            $display("FAIL random_cmd_vld_pulses: got %0d want %0d", pulses, m_pulses);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] v;
        do_clear();
        v  = 4'($urandom);
        sw = v;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); btn_enter = (i % 2 == 0);
            @(negedge clk);
        end
        btn_enter = 1'b1;
        repeat (10) @(negedge clk);
        btn_enter = 1'b0;
        repeat (12) @(negedge clk);
        m_enter(v);
        total++;
        if ({state_o, a} !== {2'b01, v}) begin
            bad++;
            $display("FAIL bounce_one_event: got st=%b a=%h want st=01 a=%h", state_o, a, v);
        end
    endtask

    task automatic test_run_hold();
        while (m_state != 3) do_enter(4'($urandom));
        sw = 4'($urandom);
        press(1'b1, 1'b0, 100);
        m_enter(sw);
        total++;
        if ({state_o, a, b, sel, en} !== {2'b00, m_a, m_b, m_sel, 1'b0}) begin
            bad++;
            $display("FAIL run_exit_hold: got st=%b a=%h b=%h sel=%b en=%b want st=00 a=%h b=%h sel=%b en=0",
                     state_o, a, b, sel, en, m_a, m_b, m_sel);
        end
    endtask

    task automatic test_simultaneous();
        int p0;
        while (m_state != 2) do_enter(4'($urandom));
        p0 = pulses;
        sw = 4'($urandom);
        press(1'b1, 1'b1, 12);
        m_reset();
        total++;
        if ({state_o, a, b, sel, en} !== 14'h0) begin
            bad++;
            $display("FAIL simul_clear_wins: got st=%b a=%h b=%h sel=%b en=%b want all 0", state_o, a, b, sel, en);
        end
        total++;
        if (pulses !== p0) begin
            bad++;
            $display("FAIL simul_no_cmd_vld: got %0d pulses want %0d", pulses, p0);
        end
    endtask

    task automatic test_async_reset();
        while (m_state != 3) do_enter(4'($urandom));
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({state_o, a, b, sel, en, cmd_vld, res_q, res_vld} !== 20'h0) begin
            bad++;
            $display("FAIL async_reset_now: got %h want 00000", {state_o, a, b, sel, en, cmd_vld, res_q, res_vld});
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({state_o, en} !== 3'b000) begin
            bad++;
            $display("FAIL async_reset_release: got st=%b en=%b want st=00 en=0", state_o, en);
        end
    endtask

`ifdef ALU4_CMD_LOADER_RESULT_LATCH_EN
    task automatic test_result();
        logic       seen;
        logic [3:0] va, vb, exp_res;
        logic [2:0] vs;
        do_clear();
        for (int r = 0; r < 2; r++) begin
            va = (r == 0) ? 4'h5 : 4'($urandom);
            vb = (r == 0) ? 4'h2 : 4'($urandom);
            vs = (r == 0) ? 3'b001 : 3'($urandom_range(0, 1));
            if (r == 1) do_enter(4'h0);
            do_enter(va);
            do_enter(vb);
            if (r == 1) begin
                total++;
                if (res_vld !== 1'b1) begin
                    bad++;
                    $display("FAIL result_held: got res_vld=%b want 1", res_vld);
                end
            end
            exp_res = (vs == 3'b001) ? (va - vb) : (va + vb);
            sw = {1'b0, vs};
            @(negedge clk);
            btn_enter = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (cmd_vld) seen = 1'b1;
            end
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL result_cmd_timeout: got no cmd_vld want pulse within 20 cycles");
            end else begin
                if (res_vld !== 1'b0) begin
                    bad++;
                    $display("FAIL result_vld_drop_r%0d: got res_vld=%b want 0", r, res_vld);
                end
                @(negedge clk);
                total++;
                if ({res_q, res_vld} !== {exp_res, 1'b1}) begin
                    bad++;
                    $display("FAIL result_latch_r%0d: got res_q=%h vld=%b want res_q=%h vld=1",
                             r, res_q, res_vld, exp_res);
                end
            end
            repeat (4) @(negedge clk);
            btn_enter = 1'b0;
            repeat (12) @(negedge clk);
            m_enter({1'b0, vs});
        end
        do_clear();
        total++;
        if (res_vld !== 1'b0) begin
            bad++;
            $display("FAIL result_clear: got res_vld=%b want 0", res_vld);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_random();
        test_bounce();
        test_run_hold();
        test_simultaneous();
        test_async_reset();
`ifdef ALU4_CMD_LOADER_RESULT_LATCH_EN
        test_result();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
